// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared FSM state, master index and mask width definitions for mem_arbiter
package mem_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic M0_IDX = 1'b0;
    localparam logic M1_IDX = 1'b1;
    localparam int   MASK_W = 8;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-request round-robin tie breaker producing a one-hot grant
module rr_arb2
    import mem_bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // On a tie the master that did not win last time goes first.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant == M1_IDX) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-master, single-outstanding memory request arbiter
module mem_arbiter
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req_valid,
    output logic              m0_req_ready,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic              m0_wen,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [MASK_W-1:0] m0_wmask,
    output logic              m0_resp_valid,
    input  logic              m0_resp_ready,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req_valid,
    output logic              m1_req_ready,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic              m1_wen,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [MASK_W-1:0] m1_wmask,
    output logic              m1_resp_valid,
    input  logic              m1_resp_ready,
    output logic [DATA_W-1:0] m1_rdata,

    output logic              s_req_valid,
    input  logic              s_req_ready,
    output logic [ADDR_W-1:0] s_addr,
    output logic              s_wen,
    output logic [DATA_W-1:0] s_wdata,
    output logic [MASK_W-1:0] s_wmask,
    input  logic              s_resp_valid,
    output logic              s_resp_ready,
    input  logic [DATA_W-1:0] s_rdata
);

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              gnt_idx_q, gnt_idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wen_q, wen_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [MASK_W-1:0] wmask_q, wmask_d;

    logic [1:0]        arb_req;
    logic [1:0]        arb_grant;
    logic              accept;
    logic              in_resp;

    // Requests are only arbitrated in IDLE and never while reset is held.
    always_comb begin
        arb_req = 2'b00;
        if (!rst && (state_q == ST_IDLE)) begin
            arb_req = {m1_req_valid, m0_req_valid};
        end
    end

    rr_arb2 u_rr_arb2 (
        .req        (arb_req),
        .last_grant (last_grant_q),
        .grant      (arb_grant)
    );

    assign accept  = |arb_grant;
    assign in_resp = !rst && (state_q == ST_RESP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= M1_IDX;
            gnt_idx_q    <= M0_IDX;
            addr_q       <= '0;
            wen_q        <= 1'b0;
            wdata_q      <= '0;
            wmask_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_idx_q    <= gnt_idx_d;
            addr_q       <= addr_d;
            wen_q        <= wen_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)                        state_d = ST_REQ;
            ST_REQ:  if (s_req_ready)                   state_d = ST_RESP;
            ST_RESP: if (s_resp_valid && s_resp_ready) state_d = ST_IDLE;
            default:                                    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        last_grant_d = last_grant_q;
        gnt_idx_d    = gnt_idx_q;
        addr_d       = addr_q;
        wen_d        = wen_q;
        wdata_d      = wdata_q;
        wmask_d      = wmask_q;
        if (accept) begin
            gnt_idx_d    = arb_grant[1] ? M1_IDX : M0_IDX;
            last_grant_d = arb_grant[1] ? M1_IDX : M0_IDX;
            if (arb_grant[1]) begin
                addr_d  = m1_addr;
                wen_d   = m1_wen;
                wdata_d = m1_wdata;
                wmask_d = m1_wmask;
            end else begin
                addr_d  = m0_addr;
                wen_d   = m0_wen;
                wdata_d = m0_wdata;
                wmask_d = m0_wmask;
            end
        end
    end

    always_comb begin
        m0_req_ready  = arb_grant[0];
        m1_req_ready  = arb_grant[1];
        s_req_valid   = !rst && (state_q == ST_REQ);
        m0_resp_valid = 1'b0;
        m1_resp_valid = 1'b0;
        m0_rdata      = '0;
        m1_rdata      = '0;
        s_resp_ready  = 1'b0;
        if (in_resp) begin
            if (gnt_idx_q == M1_IDX) begin
                m1_resp_valid = s_resp_valid;
                m1_rdata      = s_rdata;
                s_resp_ready  = m1_resp_ready;
            end else begin
                m0_resp_valid = s_resp_valid;
                m0_rdata      = s_rdata;
                s_resp_ready  = m0_resp_ready;
            end
        end
    end

    // Slave request fields hold their last latched values outside REQ.
    assign s_addr  = addr_q;
    assign s_wen   = wen_q;
    assign s_wdata = wdata_q;
    assign s_wmask = wmask_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed scoreboard bench for mem_arbiter
module tb_mem_arbiter;
    import mem_bus_pkg::*;

    localparam logic [31:0] RD_KEY = 32'h8000_0413;

    typedef struct {
        logic        idx;
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [7:0]  wmask;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req_valid, m0_req_ready, m0_wen, m0_resp_valid, m0_resp_ready;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [7:0]  m0_wmask;
    logic        m1_req_valid, m1_req_ready, m1_wen, m1_resp_valid, m1_resp_ready;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [7:0]  m1_wmask;
    logic        s_req_valid, s_req_ready, s_wen, s_resp_valid, s_resp_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [7:0]  s_wmask;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_addr(m0_addr),
        .m0_wen(m0_wen), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
        .m0_resp_valid(m0_resp_valid), .m0_resp_ready(m0_resp_ready), .m0_rdata(m0_rdata),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_addr(m1_addr),
        .m1_wen(m1_wen), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
        .m1_resp_valid(m1_resp_valid), .m1_resp_ready(m1_resp_ready), .m1_rdata(m1_rdata),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_addr(s_addr),
        .s_wen(s_wen), .s_wdata(s_wdata), .s_wmask(s_wmask),
        .s_resp_valid(s_resp_valid), .s_resp_ready(s_resp_ready), .s_rdata(s_rdata)
    );

    txn_t        mq0[$], mq1[$], exp_q[$];
    txn_t        cur;
    int          acc_q[$];
    int          n_cmp = 0, n_bad = 0;
    int          cyc = 0, n_resp = 0, n_req_cyc = 0, n_rwait = 0;
    int          last_acc = 0, last_resp = 0;
    int          phase = 0;
    logic        lg = 1'b1;
    logic        pend = 1'b0;
    logic        en0 = 1'b1, en1 = 1'b1;
    int          stall = 0, hold0 = 0, hold1 = 0;
    logic [72:0] last_f = '0;

    function automatic logic [72:0] fields(input txn_t t);
        return {t.addr, t.wen, t.wdata, t.wmask};
    endfunction

    function automatic txn_t mk(input logic idx, input logic [31:0] addr, input logic wen,
                                input logic [31:0] wdata, input logic [7:0] wmask);
        txn_t t;
        t.idx = idx; t.addr = addr; t.wen = wen; t.wdata = wdata; t.wmask = wmask;
        return t;
    endfunction

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input txn_t t);
        if (t.idx) mq1.push_back(t); else mq0.push_back(t);
        exp_q.push_back(t);
    endtask

    task automatic drive();
        m0_req_valid = en0 && (mq0.size() > 0);
        if (mq0.size() > 0) begin
            m0_addr = mq0[0].addr; m0_wen = mq0[0].wen;
            m0_wdata = mq0[0].wdata; m0_wmask = mq0[0].wmask;
        end
        m1_req_valid = en1 && (mq1.size() > 0);
        if (mq1.size() > 0) begin
            m1_addr = mq1[0].addr; m1_wen = mq1[0].wen;
            m1_wdata = mq1[0].wdata; m1_wmask = mq1[0].wmask;
        end
        s_req_ready   = (stall == 0);
        s_resp_valid  = pend;
        s_rdata       = pend ? (cur.addr ^ RD_KEY) : $urandom();
        m0_resp_ready = (hold0 == 0);
        m1_resp_ready = (hold1 == 0);
    endtask

    task automatic tick();
        logic a0, a1, hsq, hsr, er0, er1, gi;
        #1;
        cyc++;
        if (rst) begin
            chk("rst_req_ready", {m0_req_ready, m1_req_ready}, 2'b00);
            chk("rst_resp_valid", {m0_resp_valid, m1_resp_valid}, 2'b00);
            chk("rst_s_valid_ready", {s_req_valid, s_resp_ready}, 2'b00);
            chk("rst_rdata", {m0_rdata, m1_rdata}, 64'h0);
        end else begin
            er0 = (phase == 0) && m0_req_valid && (!m1_req_valid || lg);
            er1 = (phase == 0) && m1_req_valid && (!m0_req_valid || !lg);
            chk("m0_req_ready", m0_req_ready, er0);
            chk("m1_req_ready", m1_req_ready, er1);
            if ((m0_req_valid && m0_req_ready) || (m1_req_valid && m1_req_ready)) begin
                if (exp_q.size() > 0) chk("grant_idx", m1_req_ready, exp_q[0].idx);
                else chk("unexpected_accept", 1'b1, 1'b0);
            end
            chk("s_req_valid", s_req_valid, phase == 1);
            if (phase == 1) begin
                n_req_cyc++;
                if (exp_q.size() > 0) chk("s_fields", {s_addr, s_wen, s_wdata, s_wmask}, fields(exp_q[0]));
            end else begin
                chk("s_fields_hold", {s_addr, s_wen, s_wdata, s_wmask}, last_f);
            end
            if (phase == 2) begin
                gi = cur.idx;
                if (s_resp_valid) n_rwait++;
                chk("resp_valid", gi ? m1_resp_valid : m0_resp_valid, s_resp_valid);
                chk("other_resp_valid", gi ? m0_resp_valid : m1_resp_valid, 1'b0);
                chk("resp_rdata", gi ? m1_rdata : m0_rdata,
                    s_resp_valid ? (cur.addr ^ RD_KEY) : s_rdata);
                chk("other_rdata", gi ? m0_rdata : m1_rdata, 32'h0);
                chk("s_resp_ready", s_resp_ready, gi ? m1_resp_ready : m0_resp_ready);
            end else begin
                chk("idle_resp", {m0_resp_valid, m1_resp_valid, s_resp_ready}, 3'b000);
                chk("idle_rdata", {m0_rdata, m1_rdata}, 64'h0);
            end
        end
        a0  = !rst && m0_req_valid && m0_req_ready;
        a1  = !rst && m1_req_valid && m1_req_ready;
        hsq = !rst && s_req_valid && s_req_ready;
        hsr = !rst && s_resp_valid && s_resp_ready;
        @(negedge clk);
        if (rst) begin
            phase = 0; pend = 1'b0; lg = 1'b1; last_f = '0;
            stall = 0; hold0 = 0; hold1 = 0;
        end else begin
            if (phase == 1 && stall > 0) stall--;
            if (phase == 2 && pend && hold0 > 0) hold0--;
            if (phase == 2 && pend && hold1 > 0) hold1--;
            if (phase == 2 && hsr) begin
                phase = 0; pend = 1'b0; n_resp++; last_resp = cyc;
            end else if (phase == 1 && hsq) begin
                phase = 2; pend = 1'b1;
                if (exp_q.size() > 0) cur = exp_q.pop_front();
            end else if (phase == 0 && (a0 || a1)) begin
                phase = 1; lg = a1; last_acc = cyc; acc_q.push_back(cyc);
                if (a1) begin last_f = fields(mq1[0]); void'(mq1.pop_front()); end
                else    begin last_f = fields(mq0[0]); void'(mq0.pop_front()); end
            end
        end
        drive();
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && phase == 0) return;
            tick();
        end
        chk("wait_done_timeout", 1'b1, 1'b0);
    endtask

    task automatic wait_phase(input int p, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (phase == p) return;
            tick();
        end
        chk("wait_phase_timeout", 1'b1, 1'b0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) tick();
        rst = 1'b0;
    endtask

    initial begin
        int resp_before;
        rst = 1'b1;
        m0_addr = '0; m0_wen = 1'b0; m0_wdata = '0; m0_wmask = '0;
        m1_addr = '0; m1_wen = 1'b0; m1_wdata = '0; m1_wmask = '0;
        cur = mk(1'b0, 32'h0, 1'b0, 32'h0, 8'h0);
        drive();
        do_reset(3);
        tick(); tick();

        // Single m0 read: accept T, slave request T+1, response T+2
        push(mk(M0_IDX, 32'h8000_0000, 1'b0, 32'h0, 8'h00));
        wait_done(20);
        chk("t1_resp_latency", last_resp - last_acc, 2);
        chk("t1_resp_count", n_resp, 1);

        // Tie after reset: m0 first, then m1 write
        do_reset(2);
        push(mk(M0_IDX, 32'h8000_0100, 1'b0, 32'h0, 8'h00));
        push(mk(M1_IDX, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 8'h0F));
        wait_done(30);

        // Eight back-to-back transactions alternate m0,m1 every 3 cycles
        acc_q.delete();
        for (int i = 0; i < 8; i++)
            push(mk(i[0], 32'h8000_2000 + 32'(i * 4), i[1], 32'h1000_0000 + 32'(i), 8'(8'h11 << (i % 4))));
        wait_done(60);
        chk("t3_accepts", acc_q.size(), 8);
        for (int i = 1; i < 8 && i < acc_q.size(); i++)
            chk("t3_accept_spacing", acc_q[i] - acc_q[i - 1], 3);

        // Slave stalls request 5 cycles; m1 arriving meanwhile waits
        en1 = 1'b0; stall = 5; n_req_cyc = 0;
        push(mk(M0_IDX, 32'h8000_3000, 1'b0, 32'h0, 8'h00));
        push(mk(M1_IDX, 32'h8000_3100, 1'b1, 32'hCAFE_F00D, 8'hF0));
        drive();
        wait_phase(1, 10);
        en1 = 1'b1;
        drive();
        wait_done(40);
        chk("t4_req_cycles", n_req_cyc, 7);

        // m1 holds resp_ready low for 3 cycles of valid response
        hold1 = 3; n_rwait = 0;
        push(mk(M1_IDX, 32'h8000_4000, 1'b0, 32'h0, 8'h00));
        drive();
        wait_done(30);
        chk("t5_resp_wait_cycles", n_rwait, 4);

        // Reset while in RESP drops the response
        hold1 = 10;
        push(mk(M1_IDX, 32'h8000_5000, 1'b0, 32'h0, 8'h00));
        drive();
        wait_phase(2, 10);
        resp_before = n_resp;
        do_reset(1);
        tick();
        chk("t6_no_resp_after_rst", n_resp, resp_before);
        push(mk(M0_IDX, 32'h8000_6000, 1'b0, 32'h0, 8'h00));
        push(mk(M1_IDX, 32'h8000_7000, 1'b1, 32'h5555_AAAA, 8'hFF));
        drive();
        wait_done(30);
        chk("t6_resp_count", n_resp - resp_before, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 32, address width of master and slave ports.
REQ-002 Parameter DATA_W, 32, data width of master and slave ports.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 m0_req_valid / m1_req_valid  in  1  request valid; m0 = instruction fetch, m1 = load/store.
REQ-006 m0_req_ready / m1_req_ready  out  1  request accepted this cycle.
REQ-007 m0_addr / m1_addr  in  ADDR_W  request address.
REQ-008 m0_wen / m1_wen  in  1  1 = write, 0 = read.
REQ-009 m0_wdata / m1_wdata  in  DATA_W  write data.
REQ-010 m0_wmask / m1_wmask  in  8  write byte mask.
REQ-011 m0_resp_valid / m1_resp_valid  out  1  response valid.
REQ-012 m0_resp_ready / m1_resp_ready  in  1  master ready for response.
REQ-013 m0_rdata / m1_rdata  out  DATA_W  read data.
REQ-014 s_req_valid  out  1;  s_req_ready  in  1  slave request handshake.
REQ-015 s_addr  out  ADDR_W;  s_wen  out  1;  s_wdata  out  DATA_W;  s_wmask  out  8  slave request fields.
REQ-016 s_resp_valid  in  1;  s_resp_ready  out  1;  s_rdata  in  DATA_W  slave response handshake and data.

Function
REQ-017 The block SHALL run FSM IDLE -> REQ -> RESP -> IDLE, at most one outstanding transaction.
REQ-018 IDLE: if exactly one mN_req_valid=1, the block SHALL assert that master's mN_req_ready combinationally, latch addr/wen/wdata/wmask and the grant index, and move to REQ.
REQ-019 IDLE with both valid: grant SHALL go to the master not in last_grant (round-robin); last_grant updates on every accept.
REQ-020 mN_req_ready SHALL be 0 in REQ and RESP, and 0 for the losing master.
REQ-021 REQ: s_req_valid=1 and s_addr/s_wen/s_wdata/s_wmask SHALL come from the latched registers, stable until s_req_ready=1; on that handshake move to RESP.
REQ-022 RESP: the granted master's resp_valid SHALL equal s_resp_valid, its rdata SHALL equal s_rdata, and s_resp_ready SHALL equal its resp_ready; on s_resp_valid & s_resp_ready move to IDLE.
REQ-023 The non-granted master SHALL see resp_valid=0 and rdata=0; outside RESP both masters SHALL see resp_valid=0, rdata=0, and s_resp_ready=0.
REQ-024 Writes SHALL complete through RESP like reads (rdata passed through, value unspecified).
REQ-025 Minimum latency: accept at T, s_req_valid at T+1, master response earliest at T+2, next accept earliest at T+3.
REQ-026 A request arriving during REQ/RESP SHALL stay pending (master holds valid) and be arbitrated in the next IDLE.
REQ-027 Outside REQ, s_req_valid SHALL be 0 and s_addr/s_wen/s_wdata/s_wmask SHALL hold their last latched values.

Reset
REQ-028 rst=1 SHALL force state=IDLE, last_grant=m1 (so m0 wins the first tie), and latched fields to 0.
REQ-029 During rst: all req_ready, resp_valid, s_req_valid, s_resp_ready SHALL be 0; rdata outputs SHALL be 0.
REQ-030 Reset mid-transaction SHALL drop the outstanding transaction with no response; the slave is reset by the same rst.

Structure
REQ-031 FSM state enum, master index constants and mask width (8) SHALL live in a shared package mem_bus_pkg.
REQ-032 Tie-breaking logic SHALL be one sub-module rr_arb2 (2 requests, last_grant in, one-hot grant out); everything else flat.

Verification
REQ-033 m0 read 0x80000000 alone, slave ready immediately, responds 0x00000413 next cycle -> m0_req_ready at T, s_req_valid at T+1, m0_resp_valid with rdata 0x00000413 at T+2, m1 signals idle throughout.
REQ-034 m0 and m1 valid together after reset, m1 write 0x80001000/0xDEADBEEF/mask 0x0F -> m0 served first; m1 accepted in following IDLE with s_wdata=0xDEADBEEF, s_wmask=0x0F.
REQ-035 Both masters continuously valid for 8 transactions -> grants alternate m0,m1,m0,... exactly.
REQ-036 s_req_ready held 0 for 5 cycles -> s_req_valid and s_addr stable all 5 cycles; m1_req_valid raised meanwhile is not accepted.
REQ-037 s_resp_valid=1 with m1_resp_ready=0 for 3 cycles -> FSM stays in RESP, s_resp_ready=0, then completes when m1_resp_ready=1.
REQ-038 rst asserted in RESP -> next cycle IDLE, all outputs at reset values, no response delivered, next tie grants m0.
